// File: rtl/tele_freq_meter.sv
// Purpose: per-channel rising-edge counter over a fixed gate window for 12 async telemetry lines.
// Latency: edge counted 2 clk after sampling; results and presence mask latched on the gate's terminal cycle.
// Backpressure: none; results hold for a full window so downstream registers need no handshake.
module tele_freq_meter #(
  parameter int GATE_CYCLES = 50_000_000,
  parameter int MIN_EDGES   = 1,
  parameter int CNT_W       = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] tele_in,
  output logic [31:0] freq_tele_ch0,
  output logic [31:0] freq_tele_ch1,
  output logic [31:0] freq_tele_ch2,
  output logic [31:0] freq_tele_ch3,
  output logic [31:0] freq_tele_ch4,
  output logic [31:0] freq_tele_ch5,
  output logic [31:0] freq_tele_ch6,
  output logic [31:0] freq_tele_ch7,
  output logic [31:0] freq_tele_ch8,
  output logic [31:0] freq_tele_ch9,
  output logic [31:0] freq_tele_ch10,
  output logic [31:0] freq_tele_ch11,
  output logic [15:0] signal_tele_ch,
  output logic        freq_update
);

  localparam int NCH = 12;
  localparam int GATE_W = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
  localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);
  localparam logic [31:0] MIN_CNT = 32'(MIN_EDGES);

  logic [NCH-1:0]    s1, s2, s3;
  logic [NCH-1:0]    edge_det;
  logic [NCH-1:0]    present;
  logic [GATE_W-1:0] gate;
  logic              terminal;
  logic [CNT_W-1:0]  cnt         [NCH];
  logic [CNT_W-1:0]  closing     [NCH];
  logic [31:0]       closing_ext [NCH];
  logic [31:0]       freq        [NCH];

  // Sync flops reset high so a line already high at reset release is not seen as an edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= '1;
      s2 <= '1;
      s3 <= '1;
    end else begin
      s1 <= tele_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign edge_det = s2 & ~s3;
  assign terminal = (gate == GATE_LAST);

  always_ff @(posedge clk) begin
    if (rst)           gate <= '0;
    else if (terminal) gate <= '0;
    else               gate <= gate + GATE_W'(1);
  end

  // Saturating count including this cycle's edge; on the terminal cycle this is the closing value.
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      closing[i]     = (&cnt[i]) ? cnt[i] : cnt[i] + CNT_W'(edge_det[i]);
      closing_ext[i] = '0;
      closing_ext[i][CNT_W-1:0] = closing[i];
      present[i]     = (closing_ext[i] >= MIN_CNT);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NCH; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) cnt[i] <= terminal ? '0 : closing[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NCH; i++) freq[i] <= '0;
      signal_tele_ch <= '0;
      freq_update    <= 1'b0;
    end else begin
      freq_update <= terminal;
      if (terminal) begin
        for (int i = 0; i < NCH; i++) freq[i] <= closing_ext[i];
        signal_tele_ch <= {4'b0000, present};
      end
    end
  end

  assign freq_tele_ch0  = freq[0];
  assign freq_tele_ch1  = freq[1];
  assign freq_tele_ch2  = freq[2];
  assign freq_tele_ch3  = freq[3];
  assign freq_tele_ch4  = freq[4];
  assign freq_tele_ch5  = freq[5];
  assign freq_tele_ch6  = freq[6];
  assign freq_tele_ch7  = freq[7];
  assign freq_tele_ch8  = freq[8];
  assign freq_tele_ch9  = freq[9];
  assign freq_tele_ch10 = freq[10];
  assign freq_tele_ch11 = freq[11];

endmodule

// File: doc/tele_freq_meter.md
# tele_freq_meter

Measures the input frequency of 12 telemetry channels by counting rising edges over a fixed gate window. It produces the per-channel 32-bit `freq_tele_ch0..11` words and the 16-bit `signal_tele_ch` presence mask that the CPU read-register block double-registers and serves at addresses 50–61 and 10. It sits directly upstream of that block, in the same `clk` domain. The raw telemetry lines are asynchronous and are synchronized here.

## Interface
- `GATE_CYCLES`, default 50_000_000: gate window length in `clk` cycles (1 s at 50 MHz); legal range ≥ 4.
- `MIN_EDGES`, default 1: minimum edges per window for a channel's presence bit to be set; legal range ≥ 1.
- `CNT_W`, default 32: edge-counter width; legal range 4..32. Results are zero-extended to 32 bits.
- `clk`  in  1  system clock; single clock domain for the whole block.
- `rst`  in  1  reset, synchronous, active-high.
- `tele_in`  in  12  raw asynchronous telemetry lines; bit i maps to channel i.
- `freq_tele_ch0` … `freq_tele_ch11`  out  32 each  edge count of the last completed window for each channel.
- `signal_tele_ch`  out  16  bit i = channel i presence (i = 0..11); bits 15:12 are always 0.
- `freq_update`  out  1  one-cycle pulse, asserted in the same cycle the new results first appear on the outputs.

## Operation
- **Synchronizer.** Each channel has three flops: `s1`, `s2`, `s3`. `s1` samples `tele_in`, `s2` samples `s1`, `s3` samples `s2`. On reset all three load 1, so a line that is high when reset releases does not produce a spurious edge.
- **Edge detect.** `edge_i = s2_i & ~s3_i`. This is one cycle of qualification per rising edge.
- **Edge counters.** Each channel has a `CNT_W`-bit counter that increments on `edge_i`. It saturates at all-ones and never wraps.
- **Gate counter.** Counts 0 … `GATE_CYCLES-1` and then wraps to 0. The cycle with `gate == GATE_CYCLES-1` is the terminal cycle.
- **Terminal-cycle action** (all on the same clock edge):
  - `freq_tele_chi <= zero-extended(cnt_i + edge_i)`, saturated. An edge detected in the terminal cycle belongs to the closing window.
  - `cnt_i <= 0`.
  - `signal_tele_ch[i] <= (closing count ≥ MIN_EDGES)`.
  - `freq_update <= 1`.
- **Non-terminal cycles.** `freq_update <= 0`. The result outputs hold their values.
- There is no state machine beyond the gate counter; the block runs continuously from reset release.
- **Reset mid-window.** The partial window is discarded. All counters clear, all outputs clear, and the gate counter restarts at 0.

## Timing
- **Reset values.** All `freq_tele_chi` = 0, `signal_tele_ch` = 0, `freq_update` = 0, gate counter = 0, edge counters = 0, sync flops = 1.
- **Input-to-count latency.** A rising edge on `tele_in` sampled at clock edge k is reflected in `cnt_i` after edge k+2.
  - An edge sampled at k is therefore counted in the window containing cycle k+2.
  - Edges sampled in the last 2 cycles of a window are counted in the following window.
- **First window.** The first `freq_update` pulse follows `GATE_CYCLES` cycles after reset deasserts. Results update exactly every `GATE_CYCLES` cycles after that.
- **Input bandwidth.** High and low phases must each be ≥ 2 `clk` cycles to be counted reliably, giving a maximum countable frequency of f_clk/4. Shorter pulses may be missed; they are never double-counted.
- **Output stability.** Results are stable for `GATE_CYCLES` cycles. The downstream double-register needs no handshake.
- **Latch/clear concurrency.** The output latch and the counter clear happen on the same edge, so no edge is lost or double-counted across the boundary.

## Test plan
- **Reset.** Assert `rst` for 5 cycles with arbitrary `tele_in` → all outputs 0. Drive `tele_in` = 12'hFFF steady from reset → first window reports 0 on every channel and `signal_tele_ch` = 0.
- **Basic count.** `GATE_CYCLES` = 1000; ch0 is a square wave with period 10 cycles, ch5 has period 40 cycles, all others idle → after the second `freq_update`: ch0 = 100, ch5 = 25, others 0, `signal_tele_ch` = 16'h0021.
- **Boundary edge.** `GATE_CYCLES` = 100; single ch3 rising edge placed so `edge_3` fires in the terminal cycle → counted in the closing window (ch3 = 1). Shift the edge one cycle later → ch3 = 0 in that window and 1 in the next.
- **Reset mid-window.** Assert `rst` for 1 cycle at cycle 50 of a 100-cycle window while ch1 toggles → outputs clear immediately, next `freq_update` arrives exactly 100 cycles after reset release, and the count covers only post-reset edges.
- **Threshold and saturation.** Set `MIN_EDGES` = 3 and `CNT_W` = 4, with `GATE_CYCLES` = 200.
  - ch2 gets 2 edges → ch2 = 2, bit 2 = 0.
  - ch7 gets 20 edges → ch7 = 15 (saturated), bit 7 = 1.
- **Pulse width.** ch9 driven with 1-cycle-high pulses every 3 cycles, then 2-high/2-low → the first pattern reports ≤ the true count with no overcount; the second reports the exact count (`GATE_CYCLES`/4).
